// File: rtl/alu_arb.sv
// Round-robin two-requester issue arbiter for the shared 8-bit ALU, with bounded lock for multi-byte runs.
// Grant is combinational (0-cycle issue); results return 1 cycle after issue and cannot be back-pressured.
module alu_arb #(
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       r0_valid,
    output logic       r0_ready,
    input  logic [2:0] r0_op,
    input  logic [7:0] r0_a,
    input  logic [7:0] r0_b,
    input  logic [2:0] r0_shamt,
    input  logic       r0_lock,

    input  logic       r1_valid,
    output logic       r1_ready,
    input  logic [2:0] r1_op,
    input  logic [7:0] r1_a,
    input  logic [7:0] r1_b,
    input  logic [2:0] r1_shamt,
    input  logic       r1_lock,

    output logic       r0_resp_valid,
    output logic       r1_resp_valid,
    output logic [7:0] resp_data,
    output logic [3:0] resp_flags,

    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    output logic [2:0] alu_shamt,
    input  logic [7:0] alu_out,
    input  logic [3:0] alu_flags
);

    typedef enum logic [1:0] {
        ST_RR    = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_e;

    // A lock of length 1 would release on entry, so such builds never enter a lock state.
    localparam bit         LOCK_EN   = (LOCK_MAX > 1);
    localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

    state_e     state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic       resp_pend_q, resp_pend_d;
    logic       resp_id_q, resp_id_d;

    logic       gnt0, gnt1;
    logic [7:0] lock_inc;
    logic       lock_expire;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_RR: begin
                    if (r0_valid && r1_valid) begin
                        gnt0 = last_q;
                        gnt1 = !last_q;
                    end else begin
                        gnt0 = r0_valid;
                        gnt1 = r1_valid;
                    end
                end
                ST_LOCK0: gnt0 = r0_valid;
                ST_LOCK1: gnt1 = r1_valid;
                default: ;
            endcase
        end
    end

    assign r0_ready = gnt0;
    assign r1_ready = gnt1;

    always_comb begin
        alu_a     = 8'd0;
        alu_b     = 8'd0;
        alu_op    = 3'd0;
        alu_shamt = 3'd0;
        if (gnt0) begin
            alu_a     = r0_a;
            alu_b     = r0_b;
            alu_op    = r0_op;
            alu_shamt = r0_shamt;
        end else if (gnt1) begin
            alu_a     = r1_a;
            alu_b     = r1_b;
            alu_op    = r1_op;
            alu_shamt = r1_shamt;
        end
    end

    assign lock_inc    = lock_cnt_q + 8'd1;
    assign lock_expire = (lock_inc == LOCK_LAST);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        lock_cnt_d  = lock_cnt_q;
        resp_pend_d = gnt0 | gnt1;
        resp_id_d   = resp_id_q;

        if (gnt0 || gnt1) begin
            last_d    = gnt1;
            resp_id_d = gnt1;
        end

        case (state_q)
            ST_RR: begin
                lock_cnt_d = 8'd0;
                if (LOCK_EN && gnt0 && r0_lock) begin
                    state_d = ST_LOCK0;
                end else if (LOCK_EN && gnt1 && r1_lock) begin
                    state_d = ST_LOCK1;
                end
            end
            ST_LOCK0: begin
                lock_cnt_d = lock_inc;
                // Forced release hands the next tie to requester 1.
                if (lock_expire) begin
                    state_d    = ST_RR;
                    lock_cnt_d = 8'd0;
                    last_d     = 1'b0;
                end else if (gnt0 && !r0_lock) begin
                    state_d    = ST_RR;
                    lock_cnt_d = 8'd0;
                end
            end
            ST_LOCK1: begin
                lock_cnt_d = lock_inc;
                if (lock_expire) begin
                    state_d    = ST_RR;
                    lock_cnt_d = 8'd0;
                    last_d     = 1'b1;
                end else if (gnt1 && !r1_lock) begin
                    state_d    = ST_RR;
                    lock_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d    = ST_RR;
                lock_cnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RR;
            last_q      <= 1'b1;
            lock_cnt_q  <= 8'd0;
            resp_pend_q <= 1'b0;
            resp_id_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            lock_cnt_q  <= lock_cnt_d;
            resp_pend_q <= resp_pend_d;
            resp_id_q   <= resp_id_d;
        end
    end

    // The ALU output register lines up with resp_pend_q, so data and flags pass straight through.
    assign r0_resp_valid = rst_n & resp_pend_q & (resp_id_q == 1'b0);
    assign r1_resp_valid = rst_n & resp_pend_q & (resp_id_q == 1'b1);
    assign resp_data     = alu_out;
    assign resp_flags    = alu_flags;

endmodule
